spi_packet_scheduler: RTL and testbench

- Sequences sensor samples from the BNO085 controller into the MCU SPI read-only slave.
- Captures quaternion and gyro samples and publishes complete sample sets as one frozen snapshot for the slave to serialise.
- Raises a data-ready line to the MCU and holds the snapshot stable from publish until the CS transaction ends.
- Tracks sequence number, overruns (unread data replaced) and data staleness.

---
 rtl/spi_pkg.sv | 39 +++
 rtl/spi_packet_scheduler_cs_sync_edge.sv | 43 ++++
 rtl/spi_packet_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_spi_packet_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI packet scheduler and
//                the MCU-facing read-only SPI slave.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    localparam int          PACKET_SIZE = 16;
    localparam logic [7:0]  HEADER_BYTE = 8'hAA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } sched_state_t;

    // One complete IMU sample set; the valid bits double as freshness flags
    typedef struct packed {
        logic [15:0] quat_w;
        logic [15:0] quat_x;
        logic [15:0] quat_y;
        logic [15:0] quat_z;
        logic [15:0] gyro_x;
        logic [15:0] gyro_y;
        logic [15:0] gyro_z;
        logic        quat_valid;
        logic        gyro_valid;
    } imu_sample_t;

    // Increment that sticks at the all-ones value
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_packet_scheduler_cs_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : cs_sync_edge
//  Description : Two-flop synchroniser for the MCU chip select with one extra
//                delay stage for edge detection. All stages reset to 1 (CS
//                deasserted) so a CS held low through reset shows up as a
//                clean falling edge after release.
//  Revision    : 1.0  initial release
// ============================================================================
module cs_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_cs_n,
    output logic o_cs_meta,
    output logic o_cs_s,
    output logic o_fall,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    // Synchronise the asynchronous CS and keep a one-cycle delayed copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_dly  <= 1'b1;
        end else begin
            r_meta <= i_cs_n;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_cs_meta = r_meta;
    assign o_cs_s    = r_sync;
    assign o_fall    = r_dly & ~r_sync;
    assign o_rise    = ~r_dly & r_sync;

endmodule
`default_nettype wire

// File: rtl/spi_packet_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : spi_packet_scheduler
//  Description : Captures quaternion and gyro samples, publishes complete sets
//                as a frozen snapshot for the SPI slave, drives data-ready to
//                the MCU and tracks sequence, overruns and staleness.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_packet_scheduler
    import spi_pkg::*;
#(
    parameter bit          REQUIRE_BOTH   = 1'b1,
    parameter int unsigned MIN_GAP_CYCLES = 16,
    parameter logic [23:0] STALE_CYCLES   = 24'd3_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               quat_valid,
    input  logic signed [15:0] quat_w,
    input  logic signed [15:0] quat_x,
    input  logic signed [15:0] quat_y,
    input  logic signed [15:0] quat_z,
    input  logic               gyro_valid,
    input  logic signed [15:0] gyro_x,
    input  logic signed [15:0] gyro_y,
    input  logic signed [15:0] gyro_z,
    input  logic               cs_n,
    output logic               drdy,
    output logic [15:0]        snap_quat_w,
    output logic [15:0]        snap_quat_x,
    output logic [15:0]        snap_quat_y,
    output logic [15:0]        snap_quat_z,
    output logic [15:0]        snap_gyro_x,
    output logic [15:0]        snap_gyro_y,
    output logic [15:0]        snap_gyro_z,
    output logic               snap_quat_valid,
    output logic               snap_gyro_valid,
    output logic [7:0]         seq,
    output logic [7:0]         overrun_cnt,
    output logic               stale,
    output logic               busy
);

    localparam logic [7:0]  c_gap_load  = 8'(MIN_GAP_CYCLES - 1);
    localparam logic [23:0] c_stale_max = STALE_CYCLES - 24'd1;

    sched_state_t r_state;
    logic         r_drdy;
    logic         r_busy;
    logic [7:0]   r_gap_cnt;
    imu_sample_t  r_latest;
    imu_sample_t  r_snap;
    logic [7:0]   r_seq;
    logic [7:0]   r_ovr;
    logic [23:0]  r_stale_cnt;

    logic w_cs_meta;
    logic w_cs_s;
    logic w_fall;
    logic w_rise;
    logic w_fresh_ok;
    logic w_pub_ok;
    logic w_publish;
    logic w_republish;

    cs_sync_edge u_cs_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cs_n    (cs_n),
        .o_cs_meta (w_cs_meta),
        .o_cs_s    (w_cs_s),
        .o_fall    (w_fall),
        .o_rise    (w_rise)
    );

    // Publishing needs fresh data and CS seen high by both synchroniser stages,
    // so a CS fall already in flight blocks it
    assign w_fresh_ok  = REQUIRE_BOTH ? (r_latest.quat_valid & r_latest.gyro_valid)
                                      : (r_latest.quat_valid | r_latest.gyro_valid);
    assign w_pub_ok    = w_fresh_ok & w_cs_s & w_cs_meta;
    assign w_republish = (r_state == READY) & w_pub_ok & ~w_fall;
    assign w_publish   = ((r_state == IDLE) & w_pub_ok & ~w_fall) | w_republish;

    // Capture incoming samples; a new pulse beats the publish-clear of its flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latest <= '0;
        end else begin
            if (quat_valid) begin
                r_latest.quat_w     <= quat_w;
                r_latest.quat_x     <= quat_x;
                r_latest.quat_y     <= quat_y;
                r_latest.quat_z     <= quat_z;
                r_latest.quat_valid <= 1'b1;
            end else if (w_publish) begin
                r_latest.quat_valid <= 1'b0;
            end
            if (gyro_valid) begin
                r_latest.gyro_x     <= gyro_x;
                r_latest.gyro_y     <= gyro_y;
                r_latest.gyro_z     <= gyro_z;
                r_latest.gyro_valid <= 1'b1;
            end else if (w_publish) begin
                r_latest.gyro_valid <= 1'b0;
            end
        end
    end

    // Freeze the latest set into the snapshot and maintain seq/overrun/stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap      <= '0;
            r_seq       <= 8'd0;
            r_ovr       <= 8'd0;
            r_stale_cnt <= 24'd0;
        end else begin
            if (w_publish) begin
                r_snap      <= r_latest;
                r_seq       <= r_seq + 8'd1;
                r_stale_cnt <= 24'd0;
            end else if (r_stale_cnt < c_stale_max) begin
                r_stale_cnt <= r_stale_cnt + 24'd1;
            end
            if (w_republish) begin
                r_ovr <= sat_inc8(r_ovr);
            end
        end
    end

    // Transaction sequencing: CS fall always wins over a same-cycle publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_drdy    <= 1'b0;
            r_busy    <= 1'b0;
            r_gap_cnt <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                        r_drdy  <= 1'b0;
                    end else if (w_pub_ok) begin
                        r_state <= READY;
                        r_drdy  <= 1'b1;
                    end
                end
                READY: begin
                    if (w_fall) begin
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                        r_drdy  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (w_rise) begin
                        r_state   <= GAP;
                        r_busy    <= 1'b0;
                        r_gap_cnt <= c_gap_load;
                    end
                end
                GAP: begin
                    if (w_fall) begin
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                    end else if (r_gap_cnt == 8'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_drdy  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign drdy            = r_drdy;
    assign busy            = r_busy;
    assign seq             = r_seq;
    assign overrun_cnt     = r_ovr;
    assign stale           = (r_stale_cnt >= c_stale_max);
    assign snap_quat_w     = r_snap.quat_w;
    assign snap_quat_x     = r_snap.quat_x;
    assign snap_quat_y     = r_snap.quat_y;
    assign snap_quat_z     = r_snap.quat_z;
    assign snap_gyro_x     = r_snap.gyro_x;
    assign snap_gyro_y     = r_snap.gyro_y;
    assign snap_gyro_z     = r_snap.gyro_z;
    assign snap_quat_valid = r_snap.quat_valid;
    assign snap_gyro_valid = r_snap.gyro_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_packet_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_packet_scheduler
//  Description : Scoreboard bench for spi_packet_scheduler. Instance 0 uses
//                REQUIRE_BOTH=1, instance 1 uses REQUIRE_BOTH=0; both use a
//                short stale window of 100 cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_packet_scheduler;
    import spi_pkg::*;

    typedef struct packed {
        imu_sample_t snap;
        logic [7:0]  seq;
        logic [7:0]  ovr;
        logic        drdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        q_v  [2];
    logic [15:0] q_w  [2];
    logic [15:0] q_x  [2];
    logic [15:0] q_y  [2];
    logic [15:0] q_z  [2];
    logic        g_v  [2];
    logic [15:0] g_x  [2];
    logic [15:0] g_y  [2];
    logic [15:0] g_z  [2];
    logic        cs_n [2];

    logic        drdy_o [2];
    logic [15:0] sqw [2];
    logic [15:0] sqx [2];
    logic [15:0] sqy [2];
    logic [15:0] sqz [2];
    logic [15:0] sgx [2];
    logic [15:0] sgy [2];
    logic [15:0] sgz [2];
    logic        sqv [2];
    logic        sgv [2];
    logic [7:0]  seq_o [2];
    logic [7:0]  ovr_o [2];
    logic        stale_o [2];
    logic        busy_o [2];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    logic [7:0] prev_seq [2];

    always #5 clk = ~clk;

    spi_packet_scheduler #(
        .REQUIRE_BOTH   (1'b1),
        .MIN_GAP_CYCLES (16),
        .STALE_CYCLES   (24'd100)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .quat_valid(q_v[0]), .quat_w(q_w[0]), .quat_x(q_x[0]), .quat_y(q_y[0]), .quat_z(q_z[0]),
        .gyro_valid(g_v[0]), .gyro_x(g_x[0]), .gyro_y(g_y[0]), .gyro_z(g_z[0]),
        .cs_n(cs_n[0]), .drdy(drdy_o[0]),
        .snap_quat_w(sqw[0]), .snap_quat_x(sqx[0]), .snap_quat_y(sqy[0]), .snap_quat_z(sqz[0]),
        .snap_gyro_x(sgx[0]), .snap_gyro_y(sgy[0]), .snap_gyro_z(sgz[0]),
        .snap_quat_valid(sqv[0]), .snap_gyro_valid(sgv[0]),
        .seq(seq_o[0]), .overrun_cnt(ovr_o[0]), .stale(stale_o[0]), .busy(busy_o[0])
    );

    spi_packet_scheduler #(
        .REQUIRE_BOTH   (1'b0),
        .MIN_GAP_CYCLES (16),
        .STALE_CYCLES   (24'd100)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .quat_valid(q_v[1]), .quat_w(q_w[1]), .quat_x(q_x[1]), .quat_y(q_y[1]), .quat_z(q_z[1]),
        .gyro_valid(g_v[1]), .gyro_x(g_x[1]), .gyro_y(g_y[1]), .gyro_z(g_z[1]),
        .cs_n(cs_n[1]), .drdy(drdy_o[1]),
        .snap_quat_w(sqw[1]), .snap_quat_x(sqx[1]), .snap_quat_y(sqy[1]), .snap_quat_z(sqz[1]),
        .snap_gyro_x(sgx[1]), .snap_gyro_y(sgy[1]), .snap_gyro_z(sgz[1]),
        .snap_quat_valid(sqv[1]), .snap_gyro_valid(sgv[1]),
        .seq(seq_o[1]), .overrun_cnt(ovr_o[1]), .stale(stale_o[1]), .busy(busy_o[1])
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample set built from a base value: x=base+1, y=base+2, ...; base 0 = never loaded
    function automatic imu_sample_t mk(input logic [15:0] qb, input logic [15:0] gb,
                                       input logic qv, input logic gv);
        imu_sample_t s;
        s = '0;
        if (qb != 16'd0) begin
            s.quat_w = qb;
            s.quat_x = qb + 16'd1;
            s.quat_y = qb + 16'd2;
            s.quat_z = qb + 16'd3;
        end
        if (gb != 16'd0) begin
            s.gyro_x = gb;
            s.gyro_y = gb + 16'd1;
            s.gyro_z = gb + 16'd2;
        end
        s.quat_valid = qv;
        s.gyro_valid = gv;
        return s;
    endfunction

    task automatic push(input int d, input imu_sample_t s, input logic [7:0] sq, input logic [7:0] ov);
        exp_t e;
        e.snap = s;
        e.seq  = sq;
        e.ovr  = ov;
        e.drdy = 1'b1;
        if (d == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle sample pulse(s) on instance d
    task automatic pulse(input int d, input bit do_q, input logic [15:0] qb,
                         input bit do_g, input logic [15:0] gb);
        if (do_q) begin
            q_w[d] = qb; q_x[d] = qb + 16'd1; q_y[d] = qb + 16'd2; q_z[d] = qb + 16'd3;
            q_v[d] = 1'b1;
        end
        if (do_g) begin
            g_x[d] = gb; g_y[d] = gb + 16'd1; g_z[d] = gb + 16'd2;
            g_v[d] = 1'b1;
        end
        step(1);
        q_v[d] = 1'b0;
        g_v[d] = 1'b0;
    endtask

    // Monitor: every sequence change is a publish; pop and compare the expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_seq[0] = 8'd0;
            prev_seq[1] = 8'd0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (seq_o[d] != prev_seq[d]) begin
                    exp_t        e;
                    imu_sample_t a;
                    prev_seq[d] = seq_o[d];
                    a = '{sqw[d], sqx[d], sqy[d], sqz[d], sgx[d], sgy[d], sgz[d], sqv[d], sgv[d]};
                    if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_publish dut%0d: got seq %0d expected none", d, seq_o[d]);
                    end else begin
                        e = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
                        chk($sformatf("pub%0d_snap", d), 128'(a), 128'(e.snap));
                        chk($sformatf("pub%0d_seq", d), 128'(seq_o[d]), 128'(e.seq));
                        chk($sformatf("pub%0d_ovr", d), 128'(ovr_o[d]), 128'(e.ovr));
                        chk($sformatf("pub%0d_drdy", d), 128'(drdy_o[d]), 128'(e.drdy));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            q_v[d] = 1'b0; q_w[d] = '0; q_x[d] = '0; q_y[d] = '0; q_z[d] = '0;
            g_v[d] = 1'b0; g_x[d] = '0; g_y[d] = '0; g_z[d] = '0;
            cs_n[d] = 1'b1;
        end
        step(3);
        chk("rst_drdy",  128'(drdy_o[0]),  128'(0));
        chk("rst_busy",  128'(busy_o[0]),  128'(0));
        chk("rst_stale", 128'(stale_o[0]), 128'(0));
        chk("rst_seq",   128'(seq_o[0]),   128'(0));
        chk("rst_ovr",   128'(ovr_o[0]),   128'(0));
        chk("rst_snapqw", 128'(sqw[0]),    128'(0));
        rst_n = 1'b1;
        step(2);

        // Quat, gyro three cycles later, publish the cycle after the gyro
        push(0, mk(16'h1234, 16'h0F0F, 1'b1, 1'b1), 8'd1, 8'd0);
        pulse(0, 1'b1, 16'h1234, 1'b0, 16'h0);
        step(2);
        pulse(0, 1'b0, 16'h0, 1'b1, 16'h0F0F);
        step(2);
        chk("pub1_drdy_direct", 128'(drdy_o[0]), 128'(1));

        // Second full set while READY and no CS: republish with overrun
        push(0, mk(16'h5555, 16'h0A0A, 1'b1, 1'b1), 8'd2, 8'd1);
        pulse(0, 1'b1, 16'h5555, 1'b1, 16'h0A0A);
        step(2);

        // Transaction: drdy drops within 3 cycles, snapshot frozen while BUSY
        cs_n[0] = 1'b0;
        step(3);
        chk("busy_drdy", 128'(drdy_o[0]), 128'(0));
        chk("busy_busy", 128'(busy_o[0]), 128'(1));
        pulse(0, 1'b1, 16'h7777, 1'b1, 16'h0B0B);
        step(3);
        chk("frozen_qw",  128'(sqw[0]),   128'(16'h5555));
        chk("frozen_seq", 128'(seq_o[0]), 128'(2));
        cs_n[0] = 1'b1;
        push(0, mk(16'h7777, 16'h0B0B, 1'b1, 1'b1), 8'd3, 8'd1);
        step(19);
        chk("gap_hold_seq", 128'(seq_o[0]), 128'(2));
        step(1);
        chk("gap_pub_seq", 128'(seq_o[0]), 128'(3));

        // CS fall racing fresh data in READY: BUSY, no republish
        cs_n[0] = 1'b0;
        pulse(0, 1'b1, 16'h2222, 1'b1, 16'h0C0C);
        step(2);
        chk("race_busy", 128'(busy_o[0]), 128'(1));
        chk("race_seq",  128'(seq_o[0]),  128'(3));
        chk("race_ovr",  128'(ovr_o[0]),  128'(1));
        cs_n[0] = 1'b1;
        push(0, mk(16'h2222, 16'h0C0C, 1'b1, 1'b1), 8'd4, 8'd1);
        step(19);
        // Quat pulse lands in the publish cycle: its flag survives the clear
        push(0, mk(16'h3333, 16'h4444, 1'b1, 1'b1), 8'd5, 8'd2);
        pulse(0, 1'b1, 16'h3333, 1'b0, 16'h0);
        pulse(0, 1'b0, 16'h0, 1'b1, 16'h4444);
        step(2);
        chk("keepfresh_seq", 128'(seq_o[0]), 128'(5));
        chk("keepfresh_ovr", 128'(ovr_o[0]), 128'(2));

        // Either-fresh instance: quat-only publish, then staleness
        push(1, mk(16'h0101, 16'h0, 1'b1, 1'b0), 8'd1, 8'd0);
        pulse(1, 1'b1, 16'h0101, 1'b0, 16'h0);
        step(1);
        chk("b_pub_seq", 128'(seq_o[1]), 128'(1));
        step(98);
        chk("b_stale_before", 128'(stale_o[1]), 128'(0));
        step(1);
        chk("b_stale_set", 128'(stale_o[1]), 128'(1));
        push(1, mk(16'h0101, 16'h0D0D, 1'b0, 1'b1), 8'd2, 8'd1);
        pulse(1, 1'b0, 16'h0, 1'b1, 16'h0D0D);
        step(1);
        chk("b_stale_clear", 128'(stale_o[1]), 128'(0));

        // Reset in the middle of a transaction with CS still low
        cs_n[0] = 1'b0;
        step(3);
        chk("mid_busy", 128'(busy_o[0]), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  128'(busy_o[0]),  128'(0));
        chk("mid_rst_drdy",  128'(drdy_o[0]),  128'(0));
        chk("mid_rst_seq",   128'(seq_o[0]),   128'(0));
        chk("mid_rst_ovr",   128'(ovr_o[0]),   128'(0));
        chk("mid_rst_snap",  128'({sqw[0], sqv[0], sgv[0]}), 128'(0));
        chk("mid_rst_stale", 128'(stale_o[0]), 128'(0));
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("post_rst_busy", 128'(busy_o[0]), 128'(1));
        chk("post_rst_seq",  128'(seq_o[0]),  128'(0));
        cs_n[0] = 1'b1;
        step(5);

        chk("exp_a_drained", 128'(exp_a.size()), 128'(0));
        chk("exp_b_drained", 128'(exp_b.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
